// File: rtl/data_mem_hs.sv
// rtl/data_mem_hs.sv - handshaked RV32 data memory with wait states and post-reset clear engine
// Optional: define MISALIGN_CHECK_EN to reject misaligned halfword/word accesses with rsp_err.
module data_mem_hs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_SIZE    = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_SIZE - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [IDX_W-1:0]      r_clr_idx;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [IDX_W+1:0]      r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_init_done;

  logic                  w_rst;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_wword;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [3:0]            w_wmask;
  logic                  w_bad;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_access;
  logic                  w_commit;
  logic                  w_unused_addr;

  // Port is named rst_n but is asserted high.
  assign w_rst         = rst_n;
  assign w_unused_addr = ^req_addr[ADDR_WIDTH-1:IDX_W+2];

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign init_done = r_init_done;

  assign w_idx     = r_addr[IDX_W+1:2];
  assign w_rd_word = r_mem[w_idx];
  assign w_access  = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_err     = w_bad | w_misalign;
  assign w_commit  = w_access && r_we && !w_err;

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= S_CLEAR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_idx == LAST_IDX) w_next = S_IDLE;
      S_IDLE:  if (req_valid) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  always_comb begin
    w_bad      = 1'b0;
    w_misalign = 1'b0;
    w_load     = '0;
    w_wmask    = 4'b0000;
    w_wword    = '0;
    case (r_addr[1:0])
      2'd0:    w_byte = w_rd_word[7:0];
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      default: w_byte = w_rd_word[31:24];
    endcase
    w_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
`ifdef MISALIGN_CHECK_EN
    w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                 ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    if (r_we) begin
      case (r_funct3)
        3'b000: begin w_wmask = 4'b0001 << r_addr[1:0]; w_wword = {4{r_wdata[7:0]}}; end
        3'b001: begin w_wmask = r_addr[1] ? 4'b1100 : 4'b0011; w_wword = {2{r_wdata[15:0]}}; end
        3'b010: begin w_wmask = 4'b1111; w_wword = r_wdata; end
        default: w_bad = 1'b1;
      endcase
    end else begin
      case (r_funct3)
        3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_load = {{16{w_half[15]}}, w_half};
        3'b010:  w_load = w_rd_word;
        3'b100:  w_load = {24'd0, w_byte};
        3'b101:  w_load = {16'd0, w_half};
        default: w_bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_merged = w_rd_word;
    for (int i = 0; i < 4; i++) begin
      if (w_wmask[i]) w_merged[8*i +: 8] = w_wword[8*i +: 8];
    end
  end

  // No reset on the array itself: the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!w_rst) begin
      if (r_state == S_CLEAR) r_mem[r_clr_idx] <= '0;
      else if (w_commit)      r_mem[w_idx]     <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_clr_idx   <= '0;
      r_cnt       <= 4'd0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_init_done <= 1'b0;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == LAST_IDX) r_init_done <= 1'b1;
        end
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[IDX_W+1:0];
            r_wdata  <= req_wdata;
            r_cnt    <= 4'(WAIT_STATES);
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= (r_we || w_err) ? '0 : w_load;
            r_err   <= w_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// tb/tb_data_mem_hs.sv - directed self-checking bench for data_mem_hs
// Build with or without MISALIGN_CHECK_EN; the halfword test adapts.
module tb_data_mem_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int total = 0;
  int bad   = 0;

  data_mem_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(256), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n = 0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (req_ready !== 1'b1) begin
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, req_ready);
      bad++; total++;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                        output int lat);
    issue(we, f3, addr, wdata);
    wait_rsp(lat);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic ok = 1'b1;
    logic [31:0] rd; logic er; int lat;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
      $display("FAIL reset_outputs valid=%b err=%b rdata=%h required 0 0 0", rsp_valid, rsp_err, rsp_rdata);
      bad++;
    end
    total++;
    for (int i = 0; i < 256; i++) begin
      if (req_ready !== 1'b0 || init_done !== 1'b0) begin
        if (ok) $display("FAIL clear_phase cycle=%0d ready=%b init=%b required 0 0", i, req_ready, init_done);
        ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!ok) bad++;
    total++;
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      $display("FAIL clear_done ready=%b init=%b required 1 1", req_ready, init_done);
      bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h0000_03FC, 32'd0, rd, er, lat);
    if (rd !== 32'd0 || er !== 1'b0) begin
      $display("FAIL cleared_3fc rdata=%h err=%b required 00000000 0", rd, er); bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h0000_0010, 32'd0, rd, er, lat);
    if (rd !== 32'd0 || er !== 1'b0) begin
      $display("FAIL cleared_10 rdata=%h err=%b required 00000000 0", rd, er); bad++;
    end
    total++;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
    if (lat !== 2) begin $display("FAIL sw_latency got=%0d required 2", lat); bad++; end
    total++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      $display("FAIL sw_rsp rdata=%h err=%b required 00000000 0", rd, er); bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h0000_0010, 32'd0, rd, er, lat);
    if (lat !== 2) begin $display("FAIL lw_latency got=%0d required 2", lat); bad++; end
    total++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      $display("FAIL lw_data rdata=%h err=%b required deadbeef 0", rd, er); bad++;
    end
    total++;
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic er; int lat;
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b101, 3'b010};
    logic [31:0] adr [6] = '{32'h21, 32'h21, 32'h20, 32'h22, 32'h22, 32'h20};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8000,
                             32'hFFFF_8001, 32'h0000_8001, 32'h8001_8000};
    access(1'b1, 3'b000, 32'h21, 32'h0000_0080, rd, er, lat);
    if (er !== 1'b0) begin $display("FAIL sb_err got=%b required 0", er); bad++; end
    total++;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, f3[i], adr[i], 32'd0, rd, er, lat);
      if (rd !== exp[i] || er !== 1'b0) begin
        $display("FAIL subword_load_%0d rdata=%h err=%b required %h 0", i, rd, er, exp[i]); bad++;
      end
      total++;
    end
    access(1'b1, 3'b001, 32'h22, 32'h5555_8001, rd, er, lat);
    for (int i = 3; i < 6; i++) begin
      access(1'b0, f3[i], adr[i], 32'd0, rd, er, lat);
      if (rd !== exp[i] || er !== 1'b0) begin
        $display("FAIL subword_load_%0d rdata=%h err=%b required %h 0", i, rd, er, exp[i]); bad++;
      end
      total++;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat;
    logic ok = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 32'd0);
    wait_rsp(lat);
    rd = rsp_rdata; er = rsp_err;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 2) begin
      $display("FAIL bp_first rdata=%h err=%b lat=%0d required deadbeef 0 2", rd, er, lat); bad++;
    end
    total++;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0) begin
        if (ok) $display("FAIL bp_hold cycle=%0d valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, rd, er);
        ok = 1'b0;
      end
    end
    if (!ok) bad++;
    total++;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL bp_release valid=%b ready=%b required 0 1", rsp_valid, req_ready); bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
    if (rd !== 32'hDEAD_BEEF) begin
      $display("FAIL bp_no_store rdata=%h required deadbeef", rd); bad++;
    end
    total++;
  endtask

  task automatic test_invalid;
    logic [31:0] rd; logic er; int lat;
    logic        we  [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0]  f3  [3] = '{3'b111, 3'b100, 3'b011};
    access(1'b1, 3'b010, 32'h0, 32'h1234_5678, rd, er, lat);
    for (int i = 0; i < 3; i++) begin
      access(we[i], f3[i], 32'h0, 32'hFFFF_FFFF, rd, er, lat);
      if (rd !== 32'd0 || er !== 1'b1) begin
        $display("FAIL invalid_%0d rdata=%h err=%b required 00000000 1", i, rd, er); bad++;
      end
      total++;
    end
    access(1'b0, 3'b010, 32'h0, 32'd0, rd, er, lat);
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      $display("FAIL invalid_no_write rdata=%h err=%b required 12345678 0", rd, er); bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h400, 32'd0, rd, er, lat);
    if (rd !== 32'h1234_5678) begin
      $display("FAIL alias_400 rdata=%h required 12345678", rd); bad++;
    end
    total++;
    access(1'b1, 3'b010, 32'h0000_0804, 32'hAAAA_5555, rd, er, lat);
    access(1'b0, 3'b010, 32'h4, 32'd0, rd, er, lat);
    if (rd !== 32'hAAAA_5555) begin
      $display("FAIL alias_804 rdata=%h required aaaa5555", rd); bad++;
    end
    total++;
  endtask

  task automatic test_halfword;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 3'b001, 32'h3, 32'h0000_ABCD, rd, er, lat);
`ifdef MISALIGN_CHECK_EN
    if (er !== 1'b1 || rd !== 32'd0) begin
      $display("FAIL sh_misalign err=%b rdata=%h required 1 00000000", er, rd); bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h0, 32'd0, rd, er, lat);
    if (rd !== 32'h1234_5678) begin
      $display("FAIL sh_misalign_mem rdata=%h required 12345678", rd); bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h2, 32'd0, rd, er, lat);
    if (er !== 1'b1 || rd !== 32'd0) begin
      $display("FAIL lw_misalign err=%b rdata=%h required 1 00000000", er, rd); bad++;
    end
    total++;
`else
    if (er !== 1'b0) begin
      $display("FAIL sh_unaligned_err err=%b required 0", er); bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h0, 32'd0, rd, er, lat);
    if (rd !== 32'hABCD_5678) begin
      $display("FAIL sh_unaligned_mem rdata=%h required abcd5678", rd); bad++;
    end
    total++;
    access(1'b0, 3'b010, 32'h2, 32'd0, rd, er, lat);
    if (er !== 1'b0 || rd !== 32'hABCD_5678) begin
      $display("FAIL lw_unaligned err=%b rdata=%h required 0 abcd5678", er, rd); bad++;
    end
    total++;
`endif
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    test_reset;
    test_word;
    test_subword;
    test_backpressure;
    test_invalid;
    test_halfword;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
Parametrised successor to the CPU data memory.
- Same RISC-V funct3 load/store semantics: sb/sh/sw, lb/lh/lw/lbu/lhu.
- Adds a valid/ready request and response handshake, configurable wait states, parametrised depth, and a sequential post-reset clear engine.
- Sits between the MEM pipeline stage and the word-addressed data RAM. The stage stalls on req_ready/rsp_valid.

Parameters:
DATA_WIDTH, 32, data word width; fixed at 32 for RV32 funct3 semantics
ADDR_WIDTH, 32, byte address width
MEM_SIZE, 256, number of words; power of two, minimum 4
WAIT_STATES, 1, extra cycles between request accept and memory access; range 0..15

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; synchronous, active-high (asserted = 1)
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V access size/sign code
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors
rsp_err  out  1  request rejected, no memory side effect
init_done  out  1  clear sequence finished

Behaviour:
- States: CLEAR, IDLE, WAIT, RESP.
- Reset (rst_n=1 at a clock edge):
  - state=CLEAR, clr_idx=0, wait counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; req_ready=0 (req_ready is 1 only in IDLE).
  - Reset overrides all activity. An in-flight request is dropped with no write, unless its commit edge has already passed.
- CLEAR:
  - Writes 0 to word clr_idx each cycle, incrementing clr_idx.
  - At clr_idx==MEM_SIZE-1: write, go to IDLE, set init_done=1; it stays 1 until the next reset.
  - CLEAR lasts exactly MEM_SIZE cycles.
- IDLE:
  - On req_valid&&req_ready, latch we/funct3/addr/wdata, load counter=WAIT_STATES, go to WAIT.
  - Input ports are not sampled after the accept edge.
- WAIT:
  - If counter!=0: decrement.
  - Else, on this edge: perform the access (store commits, load data captured into rsp_rdata), set rsp_err, go to RESP.
  - Accept-to-rsp_valid latency is WAIT_STATES+1 cycles.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready=1.
  - On that edge: rsp_valid=0, go to IDLE.
  - The next request can be accepted one cycle later (no same-cycle overlap).
- Word index = req_addr[log2(MEM_SIZE)+1:2]; addresses above capacity wrap modulo MEM_SIZE.
- Stores:
  - sb writes byte lane addr[1:0] from wdata[7:0].
  - sh writes half lane addr[1] from wdata[15:0].
  - sw writes the full word.
  - Unselected lanes are preserved.
- Loads:
  - lb/lh sign-extend; lbu/lhu zero-extend; lw returns the word.
  - Lane selection is the same as for stores.
- Invalid funct3 (011, 110, 111; stores also 100, 101): no write, rsp_err=1, rsp_rdata=0.
- Stores: rsp_rdata=0, rsp_err=0 on success.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - lh/lhu/sh with addr[0]=1 → error response.
  - lw/sw with addr[1:0]!=0 → error response.
  - Error response means rsp_err=1, rsp_rdata=0, no write.
- Undefined:
  - No alignment error.
  - Halfword uses addr[1] and ignores addr[0]; word ignores addr[1:0].

Test Plan:
- Reset, then run with MEM_SIZE=256 → req_ready=0 and init_done=0 for 256 cycles, then both 1; lw of any address returns 0.
- sw 0xDEADBEEF @0x10, then lw @0x10 with WAIT_STATES=1 → rsp_valid 2 cycles after each accept; rdata=0xDEADBEEF, err=0.
- sb 0x80 @0x21, then lb @0x21 → 0xFFFFFF80; lbu @0x21 → 0x00000080; lw @0x20 → 0x00008000.
- Hold rsp_ready=0 for 5 cycles after a load → rsp_valid, rdata and err stable; req_ready=0; no new accept. Release → IDLE next cycle.
- funct3=3'b111 store @0x0 after sw 0x12345678 @0x0 → err=1, rdata=0; lw @0x0 still returns 0x12345678. Address 0x400 with MEM_SIZE=256 aliases word 0.
- With MISALIGN_CHECK_EN: sh @0x3 → err=1, memory unchanged. Without it: sh 0xABCD @0x3 → lw @0x0 upper half = 0xABCD.
